// File: rtl/mem_stage_if.sv
// Data-bus interface between the MEM stage and the memory system.
//   bus_req   : access request, held until ack or abort (master -> slave)
//   bus_we    : 1 = write (master -> slave)
//   bus_addr  : word address, low two bits always 0 (master -> slave)
//   bus_wdata : write data (master -> slave)
//   bus_be    : byte enables, lane0 = bits[7:0] (master -> slave)
//   bus_rdata : read data, valid with bus_ack (slave -> master)
//   bus_ack   : one-cycle completion strobe (slave -> master)
interface mem_stage_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage. Registers EX results and performs LW/LB/SW/SB accesses
// over a req/ack bus. Word loads pass through, byte loads are sign-extended,
// byte stores are replicated across all lanes with a one-hot byte enable.
// Holds IF/ID/EX (mem_busy) while an access is outstanding.
// Ports:
//   clk, rst        : clock, async active-high reset
//   ex_*            : EX stage outputs (result/address, store data, size,
//                     read/write strobes, GPR write enable and index)
//   mem_busy        : stall to upstream, high while in ACCESS
//   bus             : data bus (master side)
//   bus_error       : one-cycle pulse on misaligned word access or timeout
//   wb_*            : write-back to WB, also the MEM->ID forwarding source
module mem_stage #(
  parameter int TIMEOUT = 15  // ACCESS cycles without ack before abort, 0 = none
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        ex_result,
  input  logic [31:0]        ex_mem_data,
  input  logic               ex_load_byte,
  input  logic               ex_mem_read,
  input  logic               ex_mem_write,
  input  logic               ex_reg_write,
  input  logic [4:0]         ex_write_reg,
  output logic               mem_busy,
  mem_stage_if.master        bus,
  output logic               bus_error,
  output logic               wb_reg_write,
  output logic [4:0]         wb_write_reg,
  output logic [31:0]        wb_data
);

  localparam int NUM_LANES = 4;
  localparam int CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;

  // Stage registers for the fields still needed when the access completes.
  logic [1:0]        r_lane;
  logic              r_byte;
  logic              r_read;
  logic              r_reg_write;
  logic [4:0]        r_write_reg;

  logic              r_bus_req;
  logic              r_bus_we;
  logic [31:0]       r_bus_addr;
  logic [31:0]       r_bus_wdata;
  logic [3:0]        r_bus_be;
  logic              r_bus_error;
  logic              r_wb_reg_write;
  logic [4:0]        r_wb_write_reg;
  logic [31:0]       r_wb_data;

  logic              w_mem_op;
  logic              w_misalign;
  logic              w_timeout;
  logic [NUM_LANES-1:0] w_sb_be;
  logic [31:0]       w_sb_wdata;
  logic [7:0]        w_ld_byte;
  logic [31:0]       w_load_data;

  assign w_mem_op   = ex_mem_read | ex_mem_write;
  assign w_misalign = !ex_load_byte && (ex_result[1:0] != 2'b00);
  assign w_timeout  = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

  // Byte-lane steering: one-hot enable and replicated data for SB,
  // lane extraction for LB using the latched address offset.
  always_comb begin
    w_sb_be    = '0;
    w_sb_wdata = '0;
    w_ld_byte  = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      w_sb_be[k]          = (ex_result[1:0] == 2'(k));
      w_sb_wdata[8*k +: 8] = ex_mem_data[7:0];
      if (r_lane == 2'(k)) w_ld_byte = bus.bus_rdata[8*k +: 8];
    end
  end

  assign w_load_data = r_byte ? {{24{w_ld_byte[7]}}, w_ld_byte} : bus.bus_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_lane         <= '0;
      r_byte         <= 1'b0;
      r_read         <= 1'b0;
      r_reg_write    <= 1'b0;
      r_write_reg    <= '0;
      r_bus_req      <= 1'b0;
      r_bus_we       <= 1'b0;
      r_bus_addr     <= '0;
      r_bus_wdata    <= '0;
      r_bus_be       <= '0;
      r_bus_error    <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_write_reg <= '0;
      r_wb_data      <= '0;
    end else begin
      r_bus_error <= 1'b0;
      case (r_state)
        IDLE: begin
          r_lane      <= ex_result[1:0];
          r_byte      <= ex_load_byte;
          r_read      <= ex_mem_read;
          r_reg_write <= ex_reg_write;
          r_write_reg <= ex_write_reg;
          r_cnt       <= '0;
          if (!w_mem_op) begin
            // r0 is hardwired, so never report a write to it
            r_wb_reg_write <= ex_reg_write && (ex_write_reg != 5'd0);
            r_wb_write_reg <= ex_write_reg;
            r_wb_data      <= ex_result;
          end else if (w_misalign) begin
            r_wb_reg_write <= 1'b0;
            r_bus_error    <= 1'b1;
          end else begin
            r_state        <= ACCESS;
            r_bus_req      <= 1'b1;
            r_bus_we       <= ex_mem_write;
            r_bus_addr     <= {ex_result[31:2], 2'b00};
            // Byte loads fetch the whole word and pick the lane on return.
            r_bus_be       <= (ex_load_byte && ex_mem_write) ? w_sb_be : 4'hF;
            r_bus_wdata    <= (ex_load_byte && ex_mem_write) ? w_sb_wdata : ex_mem_data;
            r_wb_reg_write <= 1'b0;
          end
        end
        ACCESS: begin
          // Ack is checked first so it wins over a timeout in the same cycle.
          if (bus.bus_ack) begin
            r_state        <= IDLE;
            r_bus_req      <= 1'b0;
            r_cnt          <= '0;
            r_wb_reg_write <= r_read && r_reg_write && (r_write_reg != 5'd0);
            r_wb_write_reg <= r_write_reg;
            if (r_read) r_wb_data <= w_load_data;
          end else if (w_timeout) begin
            r_state        <= IDLE;
            r_bus_req      <= 1'b0;
            r_cnt          <= '0;
            r_bus_error    <= 1'b1;
            r_wb_reg_write <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_busy      = (r_state == ACCESS);
  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_wdata = r_bus_wdata;
  assign bus.bus_be    = r_bus_be;
  assign bus_error     = r_bus_error;
  assign wb_reg_write  = r_wb_reg_write;
  assign wb_write_reg  = r_wb_write_reg;
  assign wb_data       = r_wb_data;

endmodule
